// File: rtl/hub75_bcm_driver_if.sv
// Pixel-store read bus for the HUB75 BCM driver.
//   rd_row  : row address presented to the store (driver -> store)
//   rd_col  : column address presented to the store (driver -> store)
//   rd_top  : {R,G,B} pixel for the top half-panel, one cycle after the address
//   rd_bot  : {R,G,B} pixel for the bottom half-panel, one cycle after the address
// The driver uses the master modport and the pixel store uses the slave modport.
interface hub75_bcm_driver_if #(
  parameter int COLS     = 32,
  parameter int ROW_BITS = 5,
  parameter int DEPTH    = 4
);
  logic [ROW_BITS-1:0]      rd_row;
  logic [$clog2(COLS)-1:0]  rd_col;
  logic [3*DEPTH-1:0]       rd_top;
  logic [3*DEPTH-1:0]       rd_bot;

  modport master (output rd_row, output rd_col, input rd_top, input rd_bot);
  modport slave  (input rd_row, input rd_col, output rd_top, output rd_bot);
endinterface

// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix scan driver with binary-code-modulated colour depth.
// For each row pair and each bit plane it shifts COLS pixels out to the panel,
// blanks, latches, and then lights the row for BASE_ON<<plane cycles.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   enable          : run scanning (sampled in IDLE and at the end of each ON period)
//   pix             : pixel-store read bus (address out, top/bottom pixels in)
//   row_sel         : panel row address lines A..E
//   sclk            : panel shift clock
//   r1,g1,b1        : top-half colour bit of the current plane
//   r2,g2,b2        : bottom-half colour bit of the current plane
//   lat             : panel latch, active high
//   oe_n            : panel output enable, active low
//   frame_start     : one-cycle pulse when row 0 / plane 0 begins shifting
module hub75_bcm_driver #(
  parameter int COLS     = 32,
  parameter int ROW_BITS = 5,
  parameter int DEPTH    = 4,
  parameter int CLK_DIV  = 2,
  parameter int BASE_ON  = 8,
  parameter int BLANK    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  hub75_bcm_driver_if.master    pix,
  output logic [ROW_BITS-1:0]   row_sel,
  output logic                  sclk,
  output logic                  r1,
  output logic                  g1,
  output logic                  b1,
  output logic                  r2,
  output logic                  g2,
  output logic                  b2,
  output logic                  lat,
  output logic                  oe_n,
  output logic                  frame_start
);

  localparam int COL_W    = $clog2(COLS);
  localparam int PLANE_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOT_LEN = 2 * CLK_DIV;
  localparam int ON_MAX   = BASE_ON * (2 ** (DEPTH - 1));
  localparam int MAX_A    = (ON_MAX > SLOT_LEN) ? ON_MAX : SLOT_LEN;
  localparam int MAX_B    = (MAX_A > BLANK) ? MAX_A : BLANK;
  // One spare code so the longest ON period always fits.
  localparam int CNT_W    = $clog2(MAX_B + 1);

  localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0]   SCLK_RISE  = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0]   DATA_CAP   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0]   LATCH_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_ON
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [PLANE_W-1:0]    plane_q, plane_d;
  logic [ROW_BITS-1:0]   row_sel_q, row_sel_d;
  logic [5:0]            rgb_q, rgb_d;
  logic                  sclk_q, sclk_d;
  logic                  lat_q, lat_d;
  logic                  oe_n_q, oe_n_d;
  logic                  frame_start_q, frame_start_d;

  // Last count value of the ON period for a plane: (BASE_ON << plane) - 1.
  function automatic logic [CNT_W-1:0] on_last(input logic [PLANE_W-1:0] p);
    logic [CNT_W-1:0] len;
    len = CNT_W'(BASE_ON) << p;
    return len - CNT_W'(1);
  endfunction

  // Pick bit p of each colour field of a packed {R,G,B} pixel.
  function automatic logic [2:0] plane_bits(input logic [3*DEPTH-1:0] px,
                                            input logic [PLANE_W-1:0] p);
    logic [DEPTH-1:0] rf, gf, bf;
    rf = px[3*DEPTH-1:2*DEPTH];
    gf = px[2*DEPTH-1:DEPTH];
    bf = px[DEPTH-1:0];
    return {rf[p], gf[p], bf[p]};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    plane_d   = plane_q;
    rgb_d     = rgb_q;
    row_sel_d = row_sel_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        // The store answers one cycle after the address, so slot cycle 1
        // holds the pixel addressed in slot cycle 0.
        if (cnt_q == DATA_CAP) begin
          rgb_d = {plane_bits(pix.rd_top, plane_q), plane_bits(pix.rd_bot, plane_q)};
        end
        if (cnt_q == SLOT_LAST) begin
          cnt_d = '0;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_BLANK;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = ST_LATCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          cnt_d   = '0;
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ON: begin
        if (cnt_q == on_last(plane_q)) begin
          cnt_d = '0;
          if (plane_q == PLANE_LAST) begin
            plane_d = '0;
            row_d   = row_q + ROW_BITS'(1);
          end else begin
            plane_d = plane_q + PLANE_W'(1);
          end
          state_d = enable ? ST_SHIFT : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Panel strobes are decoded from the next state so the registered
    // outputs line up exactly with the state they belong to.
    sclk_d        = (state_d == ST_SHIFT) && (cnt_d >= SCLK_RISE);
    lat_d         = (state_d == ST_LATCH);
    oe_n_d        = (state_d != ST_ON);
    frame_start_d = (state_d == ST_SHIFT) && (state_q != ST_SHIFT) &&
                    (row_d == '0) && (plane_d == '0);

    // Row lines move only while the panel is dark and latching.
    if ((state_d == ST_LATCH) && (state_q != ST_LATCH)) row_sel_d = row_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      row_sel_q     <= '0;
      rgb_q         <= '0;
      sclk_q        <= 1'b0;
      lat_q         <= 1'b0;
      oe_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      row_sel_q     <= row_sel_d;
      rgb_q         <= rgb_d;
      sclk_q        <= sclk_d;
      lat_q         <= lat_d;
      oe_n_q        <= oe_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix.rd_row  = row_q;
  assign pix.rd_col  = col_q;
  assign row_sel     = row_sel_q;
  assign sclk        = sclk_q;
  assign {r1, g1, b1, r2, g2, b2} = rgb_q;
  assign lat         = lat_q;
  assign oe_n        = oe_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Self-checking bench for hub75_bcm_driver (COLS=4, ROW_BITS=5, DEPTH=4).
module tb_hub75_bcm_driver;
  localparam int COLS     = 4;
  localparam int ROW_BITS = 5;
  localparam int DEPTH    = 4;
  localparam int CLK_DIV  = 2;
  localparam int BASE_ON  = 8;
  localparam int BLANK    = 2;
  localparam int NROWS    = 2 ** ROW_BITS;
  localparam int PLANE_BASE = 2 * CLK_DIV * COLS + BLANK + CLK_DIV;
  localparam int FRAME_CYC  = NROWS * (DEPTH * PLANE_BASE + BASE_ON * (2 ** DEPTH - 1));

  logic clk, reset, enable;
  logic [ROW_BITS-1:0] row_sel;
  logic sclk, r1, g1, b1, r2, g2, b2, lat, oe_n, frame_start;

  hub75_bcm_driver_if #(.COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH)) pix_if ();

  hub75_bcm_driver #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH),
    .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON), .BLANK(BLANK)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pix(pix_if),
    .row_sel(row_sel), .sclk(sclk),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .lat(lat), .oe_n(oe_n), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel content: top R is fixed 0101, top G follows the column, top B the row;
  // the bottom half uses a different mix so both halves are distinguishable.
  function automatic logic [11:0] pix_fn(input logic [4:0] row, input logic [1:0] col,
                                         input logic bot);
    if (!bot) return {4'b0101, {2'b00, col}, row[3:0]};
    return {{2'b11, col}, row[4:1], 4'b1010};
  endfunction

  // Synchronous pixel store: one cycle read latency.
  always @(posedge clk) begin
    pix_if.rd_top <= pix_fn(pix_if.rd_row, pix_if.rd_col, 1'b0);
    pix_if.rd_bot <= pix_fn(pix_if.rd_row, pix_if.rd_col, 1'b1);
  end

  typedef struct packed {
    logic [4:0] row;
    logic [1:0] plane;
  } rec_t;
  rec_t sb[$];

  task automatic push_planes(input int row0, input int plane0, input int n);
    int r = row0;
    int p = plane0;
    rec_t rec;
    for (int i = 0; i < n; i++) begin
      rec.row   = 5'(r);
      rec.plane = 2'(p);
      sb.push_back(rec);
      p++;
      if (p == DEPTH) begin
        p = 0;
        r = (r + 1) % NROWS;
      end
    end
  endtask

  // Panel monitor: checks every shifted bit, latch width, ON width and row.
  int k = 0, lat_run = 0, on_run = 0, fs_count = 0, fs_cyc = 0;
  logic fs_valid = 1'b0;
  logic prev_sclk = 1'b0, prev_lat = 1'b0, prev_oe = 1'b1;
  logic [ROW_BITS-1:0] prev_row_sel = '0;

  always @(negedge clk) begin
    rec_t rec;
    logic [11:0] top, bot;
    logic [5:0] exp6, got6;
    logic [1:0] kc;
    int p;
    if (reset) begin
      k = 0; lat_run = 0; on_run = 0; fs_valid = 1'b0;
    end else begin
      if (row_sel != prev_row_sel) begin
        checks++;
        if (!lat || !oe_n) begin
          errors++;
          $display("FAIL row_sel_change: row_sel %0d->%0d with lat=%b oe_n=%b, need lat=1 oe_n=1",
                   prev_row_sel, row_sel, lat, oe_n);
        end
      end
      if (sclk && !prev_sclk) begin
        checks++;
        got6 = {r1, g1, b1, r2, g2, b2};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sclk_unexpected: sclk rise with no plane pending, data=%b", got6);
        end else begin
          rec = sb[0];
          kc = k[1:0];
          p = int'(rec.plane);
          top = pix_fn(rec.row, kc, 1'b0);
          bot = pix_fn(rec.row, kc, 1'b1);
          exp6 = {top[8+p], top[4+p], top[p], bot[8+p], bot[4+p], bot[p]};
          if (got6 !== exp6) begin
            errors++;
            $display("FAIL pixel_bits: row %0d plane %0d col %0d got %b want %b",
                     rec.row, rec.plane, k, got6, exp6);
          end
        end
        k++;
      end
      if (lat) begin
        if (!prev_lat) begin
          checks++;
          if (k != COLS) begin
            errors++;
            $display("FAIL shift_count: %0d sclk rises before latch, want %0d", k, COLS);
          end
          k = 0;
        end
        lat_run++;
      end else if (prev_lat) begin
        checks++;
        if (lat_run != CLK_DIV) begin
          errors++;
          $display("FAIL lat_width: %0d cycles, want %0d", lat_run, CLK_DIV);
        end
        lat_run = 0;
      end
      if (!oe_n) begin
        on_run++;
        checks++;
        if (sclk || lat) begin
          errors++;
          $display("FAIL on_quiet: sclk=%b lat=%b while oe_n low, want 0 0", sclk, lat);
        end
      end else if (!prev_oe) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL plane_unexpected: ON of %0d cycles with no plane pending", on_run);
        end else begin
          rec = sb.pop_front();
          if (on_run != (BASE_ON << rec.plane) || row_sel != rec.row) begin
            errors++;
            $display("FAIL on_period: row_sel %0d on %0d cycles, want row %0d on %0d (plane %0d)",
                     row_sel, on_run, rec.row, BASE_ON << rec.plane, rec.plane);
          end
        end
        on_run = 0;
      end
      if (frame_start) begin
        fs_count++;
        checks++;
        if (sb.size() == 0 || sb[0].row != 0 || sb[0].plane != 0) begin
          errors++;
          $display("FAIL frame_start_pos: pulse not at row 0 plane 0 (pending %0d)", sb.size());
        end
        if (fs_valid) begin
          checks++;
          if (cyc - fs_cyc != FRAME_CYC) begin
            errors++;
            $display("FAIL frame_period: %0d cycles, want %0d", cyc - fs_cyc, FRAME_CYC);
          end
        end
        fs_cyc = cyc;
        fs_valid = 1'b1;
      end
    end
    prev_sclk = sclk;
    prev_lat = lat;
    prev_oe = oe_n;
    prev_row_sel = row_sel;
  end

  task automatic wait_q(input int n, input int limit, input string what);
    int t = 0;
    while (sb.size() > n && t < limit) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() > n) begin
      errors++;
      $display("FAIL %s: timeout with %0d planes pending, want <= %0d", what, sb.size(), n);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    int          cycles;
    logic [21:0] exp;
    string       name;
  } vec_t;

  function automatic logic [21:0] obs();
    return {oe_n, sclk, lat, frame_start, r1, g1, b1, r2, g2, b2,
            row_sel, pix_if.rd_row, pix_if.rd_col};
  endfunction

  initial begin
    vec_t vecs[4];
    logic ok;
    int t;
    int snap;
    vecs[0] = '{1'b1, 1'b1, 6, 22'h200000, "reset_with_enable"};
    vecs[1] = '{1'b0, 1'b0, 4, 22'h200000, "idle_no_enable"};
    vecs[2] = '{1'b1, 1'b0, 2, 22'h200000, "reset_no_enable"};
    vecs[3] = '{1'b0, 1'b0, 3, 22'h200000, "idle_again"};

    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reset = vecs[i].rst;
      enable = vecs[i].en;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(negedge clk);
        checks++;
        if (obs() !== vecs[i].exp) begin
          errors++;
          $display("FAIL %s: outputs %h want %h", vecs[i].name, obs(), vecs[i].exp);
        end
      end
    end

    // One full frame, two planes of the next, enable dropped mid-shift.
    push_planes(0, 0, NROWS * DEPTH + 2);
    enable = 1'b1;
    wait_q(1, FRAME_CYC + 2000, "frame_run");
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_q(0, 1000, "drain_after_disable");
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (!oe_n || sclk || lat) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_after_disable: panel active after enable drop, want oe_n=1 sclk=0 lat=0");
    end

    // Resume mid-frame, then reset in the middle of row 1's ON period.
    push_planes(0, 2, 3);
    enable = 1'b1;
    wait_q(1, 1000, "resume_run");
    t = 0;
    while (oe_n && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (oe_n) begin
      errors++;
      $display("FAIL on_wait: oe_n stayed %b, want 0", oe_n);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (obs() !== 22'h200000) begin
      errors++;
      $display("FAIL reset_mid_on: outputs %h want %h", obs(), 22'h200000);
    end
    @(negedge clk);
    snap = fs_count;
    push_planes(0, 0, 2);
    reset = 1'b0;
    t = 0;
    while (fs_count == snap && t < 4) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (fs_count == snap) begin
      errors++;
      $display("FAIL restart_frame_start: no pulse within 4 cycles, want pulse");
    end
    wait_q(1, 1000, "restart_run");
    enable = 1'b0;
    wait_q(0, 1000, "restart_drain");
    repeat (10) @(negedge clk);
    checks++;
    if (fs_count != 3) begin
      errors++;
      $display("FAIL frame_start_count: %0d pulses, want 3", fs_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
